// File: rtl/mux32_4x1_pkg.sv
// mux32_4x1_pkg
//   Shared definitions for the registered 4:1 data mux.
//   - DATA_W : default data width
//   - SEL_W  : select width (four inputs, so always 2)
//   - SEL_A..SEL_D : select encodings for inputs A..D
package mux32_4x1_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux32_4x1_if.sv
// mux32_4x1_if
//   Bundles the data inputs, select and registered result of the mux.
//   - A, B, C, D : data inputs (WIDTH bits)
//   - sel        : input select
//   - E          : registered selected data
//   - E_valid    : E holds a selection captured after reset release
//   Modports: master drives data/select and observes the result;
//   slave is the mux itself.
interface mux32_4x1_if
    import mux32_4x1_pkg::*;
#(
    parameter int WIDTH = DATA_W
) ();

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    sel_t             sel;
    logic [WIDTH-1:0] E;
    logic             E_valid;

    modport master (
        output A, B, C, D, sel,
        input  E, E_valid
    );

    modport slave (
        input  A, B, C, D, sel,
        output E, E_valid
    );

endinterface

// File: rtl/mux4_comb.sv
// mux4_comb
//   Purely combinational 4:1 selection of a, b, c, d by sel.
//   - a, b, c, d : data inputs (WIDTH bits)
//   - sel        : select, encodings from the package
//   - y          : selected data, bit-exact copy of the chosen input
//   Any unknown bit on sel or on a data input drives y to all-X so a
//   bad select can never masquerade as a valid choice of input A.
module mux4_comb
    import mux32_4x1_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y
);

    logic unknown_in;

    // The XOR reduction of all inputs is X iff any input bit is X/Z;
    // synthesis treats the === against X as constant false.
    assign unknown_in = ((^{sel, a, b, c, d}) === 1'bx);

    always_comb begin
        y = '0;
        if (unknown_in) begin
            y = 'x;
        end else begin
            case (sel)
                SEL_A:   y = a;
                SEL_B:   y = b;
                SEL_C:   y = c;
                SEL_D:   y = d;
                default: y = 'x;
            endcase
        end
    end

endmodule

// File: rtl/mux32_4x1.sv
// mux32_4x1
//   Registered 4:1 mux: every rising clk edge E loads the input chosen
//   by sel (one clock latency, no enable). E_valid rises on the first
//   edge after reset release and stays high until the next reset.
//   - clk : clock
//   - rst : asynchronous active-high reset; clears E and E_valid at once
//   - bus : mux32_4x1_if slave (A, B, C, D, sel in; E, E_valid out)
module mux32_4x1
    import mux32_4x1_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SEL_W = mux32_4x1_pkg::SEL_W
) (
    input  logic         clk,
    input  logic         rst,
    mux32_4x1_if.slave   bus
);

    logic [WIDTH-1:0] a, b, c, d;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] e_q;
    logic             vld_q;

    assign a   = bus.A;
    assign b   = bus.B;
    assign c   = bus.C;
    assign d   = bus.D;
    assign sel = bus.sel;

    mux4_comb #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (sel),
        .y   (sel_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            e_q   <= sel_data;
            vld_q <= 1'b1;
        end
    end

    assign bus.E       = e_q;
    assign bus.E_valid = vld_q;

endmodule

// File: tb/tb_mux32_4x1.sv
// tb_mux32_4x1
//   Self-checking bench for mux32_4x1. Inputs change on the falling edge,
//   outputs are sampled 1 ns after the rising edge. The reference model
//   picks the expected word by indexing an array of the four inputs.
module tb_mux32_4x1;
    import mux32_4x1_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mux32_4x1_if #(.WIDTH(32)) bus ();

    mux32_4x1 #(.WIDTH(32), .SEL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the value captured for the currently driven inputs.
    function automatic logic [31:0] model_pick();
        logic [31:0] words [4];
        words[0] = bus.A;
        words[1] = bus.B;
        words[2] = bus.C;
        words[3] = bus.D;
        return words[int'(bus.sel)];
    endfunction

    // Wait for the next rising edge and step to the sample point.
    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.A   = 32'h0;
        bus.B   = 32'h2;
        bus.C   = 32'h4;
        bus.D   = 32'h8;
        bus.sel = SEL_A;
        #2; // before the first rising edge at 5 ns
        total++;
        if (bus.E !== 32'h0) begin
            bad++;
            $display("FAIL reset_E got=%h want=%h", bus.E, 32'h0);
        end
        total++;
        if (bus.E_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0", bus.E_valid);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp;
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (s != 0) @(negedge clk);
            bus.sel = 2'(s);
            exp = model_pick();
            for (int k = 0; k < 10; k++) begin
                edge_sample();
                total++;
                if (bus.E !== exp || bus.E_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL sweep sel=%0d got=%h/%b want=%h/1", s, bus.E, bus.E_valid, exp);
                end
            end
        end
    endtask

    task automatic test_full_width();
        logic [31:0] exp;
        @(negedge clk);
        bus.A = 32'hFFFF_FFFF;
        bus.D = 32'h8000_0001;
        for (int k = 0; k < 16; k++) begin
            bus.sel = (k % 2 == 0) ? SEL_A : SEL_D;
            exp = (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h8000_0001;
            edge_sample();
            total++;
            if (bus.E !== exp) begin
                bad++;
                $display("FAIL full_width cyc=%0d got=%h want=%h", k, bus.E, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        bus.sel = SEL_B;
        bus.C   = 32'h4;
        @(negedge clk);
        bus.sel = SEL_C;
        bus.C   = 32'h1234;
        edge_sample();
        total++;
        if (bus.E !== 32'h1234) begin
            bad++;
            $display("FAIL simultaneous got=%h want=%h", bus.E, 32'h1234);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus.sel = SEL_D;
        bus.D   = 32'h8;
        edge_sample();
        total++;
        if (bus.E !== 32'h8) begin
            bad++;
            $display("FAIL mid_reset_pre got=%h want=%h", bus.E, 32'h8);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (bus.E !== 32'h0 || bus.E_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_clear got=%h/%b want=0/0", bus.E, bus.E_valid);
        end
        #2;
        rst = 1'b0;
        edge_sample();
        total++;
        if (bus.E !== 32'h8 || bus.E_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_restore got=%h/%b want=%h/1", bus.E, bus.E_valid, 32'h8);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            bus.A   = $urandom;
            bus.B   = $urandom;
            bus.C   = $urandom;
            bus.D   = $urandom;
            bus.sel = 2'($urandom_range(0, 3));
            exp = model_pick();
            edge_sample();
            total++;
            if (bus.E !== exp || bus.E_valid !== 1'b1) begin
                bad++;
                $display("FAIL random cyc=%0d sel=%0d got=%h want=%h", k, bus.sel, bus.E, exp);
            end
        end
    endtask

    // Only meaningful on a four-state simulator; a two-state one cannot
    // represent the X select at all, so the check is skipped there.
    task automatic test_x_sel();
        logic probe;
        probe = 1'bx;
        if ($isunknown(probe)) begin
            @(negedge clk);
            bus.sel = 2'bx0;
            edge_sample();
            total++;
            if (bus.E !== {32{1'bx}}) begin
                bad++;
                $display("FAIL x_sel got=%h want=all-X", bus.E);
            end
            @(negedge clk);
            bus.sel = SEL_A;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sweep();
        test_full_width();
        test_simultaneous();
        test_mid_reset();
        test_back_to_back();
        test_x_sel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux32_4x1.md
MUX32_4X1 -- requirements
Module: mux32_4x1

Interface
REQ-001 Parameter WIDTH, default 32, data width of every data input and of E.
REQ-002 Parameter SEL_W, default 2, select width; fixed at 2 for four inputs, not user-adjustable.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 A  input  WIDTH  data input 0, chosen when sel=2'b00.
REQ-006 B  input  WIDTH  data input 1, chosen when sel=2'b01.
REQ-007 C  input  WIDTH  data input 2, chosen when sel=2'b10.
REQ-008 D  input  WIDTH  data input 3, chosen when sel=2'b11.
REQ-009 sel  input  2  input select.
REQ-010 E  output  WIDTH  registered selected data.
REQ-011 E_valid  output  1  high once E holds a selection captured after reset release.

Function
REQ-012 Each rising clk edge, E SHALL load the input chosen by sel: 00->A, 01->B, 10->C, 11->D.
- Latency is exactly one clock from sel/data sample to E.
- No gating, enable or handshake: a new value is captured every cycle.
REQ-013 Selection SHALL be a bit-exact copy of the chosen input, with no arithmetic and no width change.
REQ-014 If sel or a data input is X/Z at the sampling edge, E SHALL be all-X for that cycle.
- The mux SHALL NOT default silently to A in this case.
REQ-015 If sel and data change in the same cycle, E SHALL reflect the new sel and the new data at the next edge.
REQ-016 E SHALL hold its value between edges, with no combinational path from inputs to E.
REQ-017 E_valid SHALL go high on the first rising edge after rst deasserts and stay high until the next reset.

Reset
REQ-018 While rst=1, E SHALL be all zeros and E_valid SHALL be 0, independent of clk.
REQ-019 Reset asserted mid-operation SHALL clear E and E_valid immediately; any in-flight selection is discarded.
REQ-020 After rst deasserts, the first rising edge SHALL capture the current sel and data normally.

Structure
REQ-021 The select encodings SHALL live in the shared project package.
- Constants: SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
- Also in the package: default data width 32.
REQ-022 One sub-module, mux4_comb, SHALL hold the combinational 4:1 selection, including the X-propagation rule.
- mux32_4x1 SHALL wrap mux4_comb with the output register and the valid flag.

Verification
REQ-023 Reset: rst=1 with A=0, B=2, C=4, D=8 -> E=0 and E_valid=0 with no clock edge needed.
REQ-024 Sweep: A=0, B=32'h2, C=32'h4, D=32'h8, release reset, apply sel 0,1,2,3 with each held 100 ns.
- Required: E=0, 2, 4, 8 respectively, each one clock after the sel change; E_valid=1.
REQ-025 Full width: A=FFFF_FFFF, D=8000_0001, toggle sel between 00 and 11 every cycle.
- Required: E alternates FFFF_FFFF and 8000_0001, one-cycle delayed.
REQ-026 Simultaneous change: in one cycle set sel 01->10 and C=4->32'h1234 -> next edge E=32'h1234.
REQ-027 Mid-operation reset: pulse rst for less than one clock while E=8.
- Required: E=0 and E_valid=0 at once; first edge after release restores the selected value.
REQ-028 X on sel: sel=2'bx0 -> E is all-X on the next edge.
